// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: register address width,
// drain counter width and the debug FSM state encodings.
package pipeline_sequencer_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int DRAIN_CNT_W = 4;

    localparam logic [2:0] ST_HALTED = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_HALTED = ST_HALTED,
        S_RUN    = ST_RUN,
        S_STEP   = ST_STEP,
        S_DRAIN  = ST_DRAIN,
        S_DONE   = ST_DONE
    } seq_state_e;

endpackage

// File: rtl/pipeline_sequencer_load_use.sv
// Load-use hazard compare: the ID instruction reads a register that a load
// in EX has not produced yet. Register 0 never creates a dependency.
module load_use_detect
    import pipeline_sequencer_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  haz
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs && (id_rs == ex_rt);
    assign rt_match = id_uses_rt && (id_rt == ex_rt);
    assign haz      = ex_mem_read && (ex_rt != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer beside ID: hazard/redirect enables and flushes, the
// debug run/halt/step FSM, and the post-HALT drain of EX/MEM/WB.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_STALL_CNT = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [REG_ADDR_W-1:0]   i_id_rs,
    input  logic [REG_ADDR_W-1:0]   i_id_rt,
    input  logic                    i_id_uses_rs,
    input  logic                    i_id_uses_rt,
    input  logic                    i_id_halt,
    input  logic                    i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0]   i_ex_rt,
    input  logic                    i_pc_redirect,
    input  logic                    i_dbg_run,
    input  logic                    i_dbg_step,
    input  logic                    i_dbg_halt,
    output logic                    o_pc_en,
    output logic                    o_if_id_en,
    output logic                    o_if_id_flush,
    output logic                    o_id_ex_flush,
    output logic                    o_pipe_en,
    output logic                    o_halted,
    output logic                    o_step_done,
    output logic                    o_prog_done,
    output logic [NB_STALL_CNT-1:0] o_stall_cnt
);

    seq_state_e             state;
    seq_state_e             next_state;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic                   haz;
    logic                   load_drain;
    logic                   stall_inc;

    load_use_detect u_load_use (
        .id_rs       (i_id_rs),
        .id_rt       (i_id_rt),
        .id_uses_rs  (i_id_uses_rs),
        .id_uses_rt  (i_id_uses_rt),
        .ex_mem_read (i_ex_mem_read),
        .ex_rt       (i_ex_rt),
        .haz         (haz)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_HALTED;
        end else begin
            state <= next_state;
        end
    end

    // Advance cycles (RUN/STEP) resolve redirect > HALT decode > load-use.
    always_comb begin
        next_state    = state;
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_pipe_en     = 1'b0;
        load_drain    = 1'b0;
        stall_inc     = 1'b0;
        case (state)
            S_HALTED: begin
                if (!o_prog_done) begin
                    if (i_dbg_run) begin
                        next_state = S_RUN;
                    end else if (i_dbg_step) begin
                        next_state = S_STEP;
                    end
                end
            end
            S_RUN, S_STEP: begin
                o_pipe_en = 1'b1;
                if (i_pc_redirect) begin
                    o_pc_en       = 1'b1;
                    o_if_id_en    = 1'b1;
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end else if (i_id_halt) begin
                    o_id_ex_flush = 1'b1;
                    load_drain    = 1'b1;
                end else if (haz) begin
                    o_id_ex_flush = 1'b1;
                    stall_inc     = 1'b1;
                end else begin
                    o_pc_en    = 1'b1;
                    o_if_id_en = 1'b1;
                end
                if (load_drain) begin
                    next_state = S_DRAIN;
                end else if (state == S_STEP || i_dbg_halt) begin
                    next_state = S_HALTED;
                end
            end
            S_DRAIN: begin
                o_pipe_en     = 1'b1;
                o_id_ex_flush = 1'b1;
                if (drain_cnt == '0) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_DONE;
            end
            default: begin
                next_state = S_HALTED;
            end
        endcase
    end

    assign o_halted = (state == S_HALTED) || (state == S_DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drain_cnt   <= '0;
            o_prog_done <= 1'b0;
            o_step_done <= 1'b0;
            o_stall_cnt <= '0;
        end else begin
            if (load_drain) begin
                drain_cnt <= DRAIN_CNT_W'(DRAIN_CYCLES - 1);
            end else if (state == S_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DRAIN_CNT_W'(1);
            end
            if (state == S_DRAIN && drain_cnt == '0) begin
                o_prog_done <= 1'b1;
            end
            o_step_done <= (state == S_STEP) && (next_state == S_HALTED);
            if (stall_inc && !(&o_stall_cnt)) begin
                o_stall_cnt <= o_stall_cnt + NB_STALL_CNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer; a second narrow-counter instance
// exercises stall counter saturation in a few cycles.
module tb_pipeline_sequencer;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_halt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       pc_redirect;
    logic       dbg_run;
    logic       dbg_step;
    logic       dbg_halt;

    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en;
    logic        halted, step_done, prog_done;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_flush, s_pipe_en;
    logic        s_halted, s_step_done, s_prog_done;
    logic [3:0]  s_stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipeline_sequencer #(.DRAIN_CYCLES(4), .NB_STALL_CNT(16)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
        .i_id_halt(id_halt), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
        .i_pc_redirect(pc_redirect),
        .i_dbg_run(dbg_run), .i_dbg_step(dbg_step), .i_dbg_halt(dbg_halt),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
        .o_id_ex_flush(id_ex_flush), .o_pipe_en(pipe_en), .o_halted(halted),
        .o_step_done(step_done), .o_prog_done(prog_done), .o_stall_cnt(stall_cnt)
    );

    pipeline_sequencer #(.DRAIN_CYCLES(4), .NB_STALL_CNT(4)) u_dut_sat (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
        .i_id_halt(id_halt), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
        .i_pc_redirect(pc_redirect),
        .i_dbg_run(dbg_run), .i_dbg_step(dbg_step), .i_dbg_halt(dbg_halt),
        .o_pc_en(s_pc_en), .o_if_id_en(s_if_id_en), .o_if_id_flush(s_if_id_flush),
        .o_id_ex_flush(s_id_ex_flush), .o_pipe_en(s_pipe_en), .o_halted(s_halted),
        .o_step_done(s_step_done), .o_prog_done(s_prog_done), .o_stall_cnt(s_stall_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_halt = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; pc_redirect = 1'b0;
        dbg_run = 1'b0; dbg_step = 1'b0; dbg_halt = 1'b0;
    endtask

    task automatic set_rs_hazard(input logic [4:0] r);
        ex_mem_read = 1'b1; ex_rt = r; id_rs = r; id_uses_rs = 1'b1;
        id_uses_rt = 1'b0; id_rt = 5'd0;
    endtask

    task automatic clear_hazard();
        ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    endtask

    task automatic check_advance(input string tag);
        check({tag, "_pc_en"},    32'(pc_en),       32'd1);
        check({tag, "_if_id_en"}, 32'(if_id_en),    32'd1);
        check({tag, "_pipe_en"},  32'(pipe_en),     32'd1);
        check({tag, "_flush"},    32'({if_id_flush, id_ex_flush}), 32'd0);
        check({tag, "_halted"},   32'(halted),      32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_enables"}, 32'({pc_en, if_id_en, pipe_en}), 32'd0);
        check({tag, "_flushes"}, 32'({if_id_flush, id_ex_flush}), 32'd0);
        check({tag, "_halted"},  32'(halted), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        check_idle("reset");
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_prog_done", 32'(prog_done), 32'd0);
        check("reset_step_done", 32'(step_done), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check_idle("halted_idle");

        // 1. free run
        dbg_run = 1'b1;
        settle();
        check("halted_before_run_pc_en", 32'(pc_en), 32'd0);
        tick();
        dbg_run = 1'b0;
        settle();
        check_advance("run");
        tick();
        check_advance("run_after_drop");

        // 2. load-use hazards
        set_rs_hazard(5'd8);
        settle();
        check("haz_rs_pc_en",       32'(pc_en),       32'd0);
        check("haz_rs_if_id_en",    32'(if_id_en),    32'd0);
        check("haz_rs_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check("haz_rs_if_id_flush", 32'(if_id_flush), 32'd0);
        check("haz_rs_pipe_en",     32'(pipe_en),     32'd1);
        tick();
        check("haz_rs_stall_cnt", 32'(stall_cnt), 32'd1);
        set_rs_hazard(5'd0);
        settle();
        check("r0_pc_en",       32'(pc_en),       32'd1);
        check("r0_id_ex_flush", 32'(id_ex_flush), 32'd0);
        tick();
        check("r0_stall_cnt", 32'(stall_cnt), 32'd1);
        clear_hazard();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; id_rs = 5'd5;
        settle();
        check("haz_rt_pc_en", 32'(pc_en), 32'd0);
        tick();
        check("haz_rt_stall_cnt", 32'(stall_cnt), 32'd2);
        id_uses_rt = 1'b0;
        settle();
        check("unused_match_pc_en", 32'(pc_en), 32'd1);
        tick();
        check("unused_match_stall_cnt", 32'(stall_cnt), 32'd2);

        // 3. redirect beats hazard
        set_rs_hazard(5'd9);
        pc_redirect = 1'b1;
        settle();
        check("redir_pc_en",       32'(pc_en),       32'd1);
        check("redir_if_id_en",    32'(if_id_en),    32'd1);
        check("redir_if_id_flush", 32'(if_id_flush), 32'd1);
        check("redir_id_ex_flush", 32'(id_ex_flush), 32'd1);
        tick();
        pc_redirect = 1'b0;
        clear_hazard();
        check("redir_stall_cnt", 32'(stall_cnt), 32'd2);

        // debug halt: the request cycle still advances
        dbg_halt = 1'b1;
        settle();
        check_advance("dbg_halt_cycle");
        tick();
        dbg_halt = 1'b0;
        settle();
        check_idle("after_dbg_halt");
        tick();
        check_idle("stays_halted");

        // 4. single step
        dbg_step = 1'b1;
        settle();
        check("step_req_pc_en", 32'(pc_en), 32'd0);
        tick();
        dbg_step = 1'b0;
        settle();
        check_advance("step");
        check("step_cycle_step_done", 32'(step_done), 32'd0);
        tick();
        check_idle("step_end");
        check("step_done_pulse", 32'(step_done), 32'd1);
        tick();
        check("step_done_cleared", 32'(step_done), 32'd0);
        check_idle("step_end2");

        // step consumed by a hazard
        dbg_step = 1'b1;
        tick();
        dbg_step = 1'b0;
        set_rs_hazard(5'd3);
        settle();
        check("step_haz_pc_en",       32'(pc_en),       32'd0);
        check("step_haz_id_ex_flush", 32'(id_ex_flush), 32'd1);
        tick();
        clear_hazard();
        check("step_haz_halted",    32'(halted),    32'd1);
        check("step_haz_step_done", 32'(step_done), 32'd1);
        check("step_haz_stall_cnt", 32'(stall_cnt), 32'd3);

        // saturation on the 4-bit instance, plain count on the 16-bit one
        dbg_run = 1'b1;
        tick();
        dbg_run = 1'b0;
        set_rs_hazard(5'd12);
        for (int i = 0; i < 20; i++) tick();
        clear_hazard();
        check("stall_cnt_23",      32'(stall_cnt),   32'd23);
        check("sat_stall_cnt_max", 32'(s_stall_cnt), 32'd15);
        set_rs_hazard(5'd12);
        tick();
        clear_hazard();
        check("sat_stall_cnt_hold", 32'(s_stall_cnt), 32'd15);
        check("stall_cnt_24",       32'(stall_cnt),   32'd24);

        // 5. HALT decode and drain
        id_halt = 1'b1;
        settle();
        check("halt_dec_pc_en",       32'(pc_en),       32'd0);
        check("halt_dec_if_id_en",    32'(if_id_en),    32'd0);
        check("halt_dec_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check("halt_dec_pipe_en",     32'(pipe_en),     32'd1);
        tick();
        id_halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_redirect = (i == 1);
            dbg_halt    = (i == 2);
            settle();
            check("drain_pipe_en",     32'(pipe_en),     32'd1);
            check("drain_pc_en",       32'(pc_en),       32'd0);
            check("drain_flushes",     32'({if_id_flush, id_ex_flush}), 32'd1);
            check("drain_halted",      32'(halted),      32'd0);
            check("drain_prog_done",   32'(prog_done),   32'd0);
            tick();
        end
        pc_redirect = 1'b0;
        dbg_halt = 1'b0;
        check("done_prog_done", 32'(prog_done), 32'd1);
        check_idle("done");
        dbg_run = 1'b1;
        tick();
        tick();
        check("done_run_ignored_pc_en", 32'(pc_en),  32'd0);
        check("done_run_ignored_halted", 32'(halted), 32'd1);
        dbg_run = 1'b0;
        dbg_step = 1'b1;
        tick();
        dbg_step = 1'b0;
        settle();
        check("done_step_ignored_pc_en", 32'(pc_en), 32'd0);
        check("done_sticky", 32'(prog_done), 32'd1);

        // 6. async reset in the middle of a drain
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rerst_prog_done", 32'(prog_done), 32'd0);
        check_idle("rerst");
        dbg_run = 1'b1;
        tick();
        dbg_run = 1'b0;
        id_halt = 1'b1;
        tick();
        id_halt = 1'b0;
        tick();
        check("mid_drain_pipe_en", 32'(pipe_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_prog_done", 32'(prog_done), 32'd0);
        check("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("async_rst_step_done", 32'(step_done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_idle("post_rst_idle");
        check("post_rst_prog_done", 32'(prog_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
